// File: rtl/motor_pwm_ctrl.sv
// motor_pwm_ctrl
//   Multi-channel H-bridge PWM controller. One period counter is shared by all
//   channels. Each channel has its own latched duty word and a direction FSM
//   that inserts a dead-time whenever the direction reverses.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_STOP | bridge idle, both outputs low
//   S_FWD  | forward PWM active on f_pwm
//   S_REV  | reverse PWM active on b_pwm
//   S_DEAD | reversal in progress, both outputs low for DEAD cycles
//
// Ports
//   clk       system clock (rising edge)
//   rst_n     asynchronous active-low reset
//   halt      synchronous stop of all channels
//   forward   per-channel forward request
//   back      per-channel reverse request
//   duty      per-channel high time, channel i at [i*CNT_W +: CNT_W]
//   f_pwm     per-channel forward PWM (registered)
//   b_pwm     per-channel reverse PWM (registered)
//   dead_act  per-channel dead-time flag (registered)

module motor_pwm_ctrl #(
  parameter int CH     = 2,
  parameter int CNT_W  = 8,
  parameter int PERIOD = 100,
  parameter int DEAD   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                halt,
  input  logic [CH-1:0]       forward,
  input  logic [CH-1:0]       back,
  input  logic [CH*CNT_W-1:0] duty,
  output logic [CH-1:0]       f_pwm,
  output logic [CH-1:0]       b_pwm,
  output logic [CH-1:0]       dead_act
);

  // duty_l must be able to hold PERIOD itself, which may equal 2^CNT_W
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W:0]   PERIOD_L = (CNT_W + 1)'(PERIOD);
  localparam int               DW       = (DEAD > 1) ? $clog2(DEAD) : 1;
  localparam logic [DW-1:0]    DEAD_LD  = DW'(DEAD - 1);

  typedef enum logic [1:0] {
    S_STOP = 2'd0,
    S_FWD  = 2'd1,
    S_REV  = 2'd2,
    S_DEAD = 2'd3
  } state_t;

  logic [CNT_W-1:0] cnt;
  logic             cnt_wrap;

  assign cnt_wrap = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (halt || cnt_wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t           state, state_nx;
    logic [DW-1:0]    dead_cnt, dead_cnt_nx;
    logic [CNT_W:0]   duty_l;
    logic [CNT_W:0]   duty_cl;
    logic [CNT_W-1:0] duty_in;
    logic             req_fwd, req_rev;
    logic             raw;
    logic             f_q, b_q, d_q;

    assign duty_in = duty[i*CNT_W +: CNT_W];
    assign duty_cl = ({1'b0, duty_in} > PERIOD_L) ? PERIOD_L : {1'b0, duty_in};
    assign req_fwd = forward[i] & ~back[i];
    assign req_rev = back[i] & ~forward[i];
    // duty_l == PERIOD keeps this true for every cnt, so no glitch at wrap
    assign raw     = ({1'b0, cnt} < duty_l);

    always_comb begin
      state_nx    = state;
      dead_cnt_nx = dead_cnt;
      case (state)
        S_STOP: begin
          if (req_fwd)      state_nx = S_FWD;
          else if (req_rev) state_nx = S_REV;
        end
        S_FWD: begin
          if (req_rev) begin
            state_nx    = S_DEAD;
            dead_cnt_nx = DEAD_LD;
          end else if (!req_fwd) begin
            state_nx = S_STOP;
          end
        end
        S_REV: begin
          if (req_fwd) begin
            state_nx    = S_DEAD;
            dead_cnt_nx = DEAD_LD;
          end else if (!req_rev) begin
            state_nx = S_STOP;
          end
        end
        S_DEAD: begin
          // timer expiry picks the exit from the request seen in this last cycle
          if (dead_cnt == '0) begin
            if (req_fwd)      state_nx = S_FWD;
            else if (req_rev) state_nx = S_REV;
            else              state_nx = S_STOP;
          end else begin
            dead_cnt_nx = dead_cnt - DW'(1);
          end
        end
        default: state_nx = S_STOP;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= S_STOP;
        dead_cnt <= '0;
        duty_l   <= '0;
        f_q      <= 1'b0;
        b_q      <= 1'b0;
        d_q      <= 1'b0;
      end else if (halt) begin
        state    <= S_STOP;
        dead_cnt <= '0;
        duty_l   <= '0;
        f_q      <= 1'b0;
        b_q      <= 1'b0;
        d_q      <= 1'b0;
      end else begin
        state    <= state_nx;
        dead_cnt <= dead_cnt_nx;
        if (cnt_wrap) duty_l <= duty_cl;
        f_q      <= (state == S_FWD) && raw;
        b_q      <= (state == S_REV) && raw;
        d_q      <= (state == S_DEAD);
      end
    end

    assign f_pwm[i]    = f_q;
    assign b_pwm[i]    = b_q;
    assign dead_act[i] = d_q;
  end

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// Testbench for motor_pwm_ctrl (CH=2, CNT_W=8, PERIOD=100, DEAD=16).
// A cycle-level reference model tracks counter phase, latched duty and
// per-channel direction mode as plain integers; directed scenarios are
// followed by a randomized run.

module tb_motor_pwm_ctrl;

  localparam int CH     = 2;
  localparam int CNT_W  = 8;
  localparam int PERIOD = 100;
  localparam int DEAD   = 16;

  localparam int M_STOP = 0;
  localparam int M_FWD  = 1;
  localparam int M_REV  = 2;
  localparam int M_DEAD = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                halt;
  logic [CH-1:0]       forward;
  logic [CH-1:0]       back;
  logic [CH*CNT_W-1:0] duty;
  logic [CH-1:0]       f_pwm;
  logic [CH-1:0]       b_pwm;
  logic [CH-1:0]       dead_act;

  int tests = 0;
  int fails = 0;

  int m_cnt;
  int m_dl   [CH];
  int m_mode [CH];
  int m_left [CH];
  logic [CH-1:0] exp_f, exp_b, exp_d;

  motor_pwm_ctrl #(
    .CH(CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .DEAD(DEAD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .forward(forward), .back(back), .duty(duty),
    .f_pwm(f_pwm), .b_pwm(b_pwm), .dead_act(dead_act)
  );

  always #5 clk = ~clk;

  function automatic int req(int i);
    if (forward[i] && !back[i]) return M_FWD;
    if (back[i] && !forward[i]) return M_REV;
    return M_STOP;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int i = 0; i < CH; i++) begin
      m_dl[i] = 0; m_mode[i] = M_STOP; m_left[i] = 0;
    end
    exp_f = '0; exp_b = '0; exp_d = '0;
  endtask

  // Advances the model across one rising edge using the inputs present now.
  task automatic model_edge();
    int r, d;
    if (!rst_n || halt) begin
      model_reset();
      return;
    end
    for (int i = 0; i < CH; i++) begin
      exp_f[i] = (m_mode[i] == M_FWD) && (m_cnt < m_dl[i]);
      exp_b[i] = (m_mode[i] == M_REV) && (m_cnt < m_dl[i]);
      exp_d[i] = (m_mode[i] == M_DEAD);
      r = req(i);
      case (m_mode[i])
        M_STOP: m_mode[i] = r;
        M_FWD, M_REV: begin
          if (r == M_STOP) m_mode[i] = M_STOP;
          else if (r != m_mode[i]) begin
            m_mode[i] = M_DEAD; m_left[i] = DEAD;
          end
        end
        default: begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) m_mode[i] = r;
        end
      endcase
      if (m_cnt == PERIOD - 1) begin
        d = int'(duty[i*CNT_W +: CNT_W]);
        m_dl[i] = (d > PERIOD) ? PERIOD : d;
      end
    end
    m_cnt = (m_cnt + 1) % PERIOD;
  endtask

  task automatic check_outputs(string tag);
    tests++;
    assert (f_pwm === exp_f) else begin
      fails++;
      $error("FAIL %s f_pwm observed=%b expected=%b t=%0t", tag, f_pwm, exp_f, $time);
    end
    tests++;
    assert (b_pwm === exp_b) else begin
      fails++;
      $error("FAIL %s b_pwm observed=%b expected=%b t=%0t", tag, b_pwm, exp_b, $time);
    end
    tests++;
    assert (dead_act === exp_d) else begin
      fails++;
      $error("FAIL %s dead_act observed=%b expected=%b t=%0t", tag, dead_act, exp_d, $time);
    end
    tests++;
    assert ((f_pwm & b_pwm) === '0) else begin
      fails++;
      $error("FAIL %s overlap observed=%b expected=00 t=%0t", tag, f_pwm & b_pwm, $time);
    end
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic run(int n, string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic expect_int(string tag, int observed, int expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic count_high(int n, int ch, bit use_b, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      step("window");
      if (use_b ? b_pwm[ch] : f_pwm[ch]) hi++;
    end
  endtask

  task automatic wait_cnt(int target);
    int k = 0;
    while (m_cnt != target && k < 2 * PERIOD) begin
      step("align");
      k++;
    end
    expect_int("align_bound", m_cnt, target);
  endtask

  initial begin
    int hi, k, run_len;
    rst_n = 1'b0; halt = 1'b0; forward = '0; back = '0; duty = '0;
    model_reset();
    #1;
    check_outputs("reset_async");
    run(2, "reset_hold");
    rst_n = 1'b1;

    // ch0 forward duty 18, ch1 reverse duty 50
    forward = 2'b01; back = 2'b10;
    duty[7:0] = 8'd18; duty[15:8] = 8'd50;
    run(250, "fwd18");
    count_high(PERIOD, 0, 1'b0, hi);
    expect_int("duty18_window", hi, 18);
    count_high(PERIOD, 1, 1'b1, hi);
    expect_int("ch1_duty50_window", hi, 50);

    // duty change mid-period must not truncate the current period
    wait_cnt(5);
    duty[7:0] = 8'd10;
    run(2 * PERIOD, "duty_change");
    count_high(PERIOD, 0, 1'b0, hi);
    expect_int("duty10_window", hi, 10);

    // reversal on ch0: dead-time run length
    forward[0] = 1'b0; back[0] = 1'b1;
    k = 0;
    while (!dead_act[0] && k < 5) begin
      step("rev_wait");
      k++;
    end
    run_len = 0;
    while (dead_act[0] && run_len < 40) begin
      run_len++;
      step("dead");
    end
    expect_int("dead_len", run_len, DEAD);
    run(200, "rev_run");

    // both requests set -> stop; then duty extremes
    forward[0] = 1'b1;
    run(50, "both");
    back[0] = 1'b0;
    duty[7:0] = 8'd0;
    run(250, "duty0");
    count_high(PERIOD, 0, 1'b0, hi);
    expect_int("duty0_window", hi, 0);
    duty[7:0] = 8'd100;
    run(250, "duty100");
    count_high(PERIOD + 7, 0, 1'b0, hi);
    expect_int("duty100_window", hi, PERIOD + 7);
    duty[7:0] = 8'd200;
    run(250, "duty200");
    count_high(PERIOD + 7, 0, 1'b0, hi);
    expect_int("duty200_window", hi, PERIOD + 7);

    // halt mid-DEAD
    duty[7:0] = 8'd40;
    run(200, "pre_halt");
    forward[0] = 1'b0; back[0] = 1'b1;
    run(5, "halt_dead_pre");
    halt = 1'b1;
    run(3, "halt_dead");
    halt = 1'b0;
    run(250, "after_halt");

    // halt mid-high phase
    wait_cnt(3);
    halt = 1'b1;
    step("halt_high");
    halt = 1'b0;
    run(250, "after_halt2");

    // async reset mid-DEAD
    forward[0] = 1'b1; back[0] = 1'b0;
    run(5, "rst_dead_pre");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("rst_dead_async");
    run(2, "rst_dead_hold");
    rst_n = 1'b1;
    run(250, "after_rst");

    // async reset mid-high phase
    wait_cnt(4);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("rst_high_async");
    step("rst_high_hold");
    rst_n = 1'b1;
    run(150, "after_rst2");

    // randomized run
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(19) == 0) begin
          forward[i] = 1'($urandom_range(1));
          back[i]    = 1'($urandom_range(1));
        end
        if ($urandom_range(49) == 0) duty[i*CNT_W +: CNT_W] = 8'($urandom_range(255));
      end
      halt = ($urandom_range(149) == 0);
      step("random");
    end
    halt = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
